// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if: requester (IF/LS) and memory-engine signal bundle
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int XLEN = 64
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ack;
    logic [31:0]     if_data;

    logic            ls_req;
    logic            ls_we;
    logic [1:0]      ls_size;
    logic            ls_unsigned;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_ack;
    logic [XLEN-1:0] ls_rdata;

    logic            mm_start;
    logic            mm_op;
    logic [1:0]      mm_size;
    logic [XLEN-1:0] mm_addr;
    logic [XLEN-1:0] mm_wdata;
    logic            mm_done;
    logic [XLEN-1:0] mm_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  mm_done, mm_rdata,
        output if_ack, if_data, ls_ack, ls_rdata,
        output mm_start, mm_op, mm_size, mm_addr, mm_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output mm_done, mm_rdata,
        input  if_ack, if_data, ls_ack, ls_rdata,
        input  mm_start, mm_op, mm_size, mm_addr, mm_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one byte-serial memory engine between IF and LS
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] FETCH_SIZE = 2'b10
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0]      state;
    logic            last_grant;
    logic            owner;
    logic            lat_op;
    logic            lat_unsigned;
    logic [1:0]      lat_size;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [31:0]     if_data_q;
    logic [XLEN-1:0] ls_rdata_q;

    logic            grant_ls;
    logic            grant_if;
    logic [XLEN-1:0] load_ext;

    // Under contention the requester that did not win last time goes first.
    assign grant_ls = bus.ls_req && (!bus.if_req || (last_grant == OWN_IF));
    assign grant_if = bus.if_req && !grant_ls;

    always_comb begin
        load_ext = bus.mm_rdata;
        case (lat_size)
            2'b00:   load_ext = {{(XLEN-8){~lat_unsigned & bus.mm_rdata[7]}},
                                 bus.mm_rdata[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~lat_unsigned & bus.mm_rdata[15]}},
                                 bus.mm_rdata[15:0]};
            2'b10:   load_ext = {{(XLEN-32){~lat_unsigned & bus.mm_rdata[31]}},
                                 bus.mm_rdata[31:0]};
            default: load_ext = bus.mm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= OWN_IF;
            owner        <= OWN_IF;
            lat_op       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            if_data_q    <= '0;
            ls_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        owner        <= grant_ls;
                        last_grant   <= grant_ls;
                        lat_op       <= grant_ls & bus.ls_we;
                        lat_size     <= grant_ls ? bus.ls_size : FETCH_SIZE;
                        lat_addr     <= grant_ls ? bus.ls_addr : bus.if_addr;
                        lat_wdata    <= grant_ls ? bus.ls_wdata : '0;
                        lat_unsigned <= bus.ls_unsigned;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.mm_done) begin
                        if (owner == OWN_LS) begin
                            ls_rdata_q <= lat_op ? '0 : load_ext;
                        end else begin
                            if_data_q <= bus.mm_rdata[31:0];
                        end
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mm_start = (state == ISSUE);
    assign bus.mm_op    = lat_op;
    assign bus.mm_size  = lat_size;
    assign bus.mm_addr  = lat_addr;
    assign bus.mm_wdata = lat_wdata;

    assign bus.if_ack   = (state == RESP) && (owner == OWN_IF);
    assign bus.ls_ack   = (state == RESP) && (owner == OWN_LS);
    assign bus.if_data  = if_data_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: scoreboard bench with a byte-serial memory engine model
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus();

    mem_port_arbiter #(.XLEN(XLEN), .FETCH_SIZE(2'b10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        is_ls;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Engine model: no reset, latency of (bytes + 2) cycles, garbage above size.
    logic [7:0]  mem [0:4095];
    bit          mem_init;
    bit          eng_busy;
    int          eng_cnt;
    logic        eng_op;
    logic [1:0]  eng_size;
    logic [11:0] eng_addr;
    logic [63:0] eng_wdata;

    function automatic logic [63:0] mem_read(input logic [11:0] a, input logic [1:0] sz);
        logic [63:0] r;
        r = {8{8'hA5}};
        for (int i = 0; i < 8; i++)
            if (i < (1 << sz)) r[i*8 +: 8] = mem[a + 12'(i)];
        return r;
    endfunction

    always @(posedge clk) begin
        bus.mm_done <= 1'b0;
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'h13; mem[12'h101] <= 8'h05;
            mem[12'h102] <= 8'h10; mem[12'h103] <= 8'h00;
            mem[12'h048] <= 8'hF0;
            mem[12'h050] <= 8'h01; mem[12'h051] <= 8'h80;
            for (int i = 0; i < 8; i++) mem[12'h080 + 12'(i)] <= 8'hC0 + 8'(i);
            bus.mm_rdata <= '0;
            mem_init     <= 1'b1;
        end
        if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_busy    <= 1'b0;
                bus.mm_done <= 1'b1;
                if (eng_op) begin
                    for (int i = 0; i < 8; i++)
                        if (i < (1 << eng_size)) mem[eng_addr + 12'(i)] <= eng_wdata[i*8 +: 8];
                    bus.mm_rdata <= 64'hDEAD_BEEF_CAFE_F00D;
                end else begin
                    bus.mm_rdata <= mem_read(eng_addr, eng_size);
                end
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (bus.mm_start === 1'b1) begin
            eng_busy  <= 1'b1;
            eng_op    <= bus.mm_op;
            eng_size  <= bus.mm_size;
            eng_addr  <= bus.mm_addr[11:0];
            eng_wdata <= bus.mm_wdata;
            eng_cnt   <= (1 << bus.mm_size) + 1;
        end
    end

    task automatic drive_fetch(input logic [63:0] a);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
    endtask

    task automatic drive_ls(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [63:0] a, input logic [63:0] wd);
        bus.ls_we       = we;
        bus.ls_size     = sz;
        bus.ls_unsigned = uns;
        bus.ls_addr     = a;
        bus.ls_wdata    = wd;
        bus.ls_req      = 1'b1;
    endtask

    // Waits (bounded) for the next ack and pops the matching scoreboard entry.
    task automatic collect(output exp_t want, output exp_t got, output logic dual,
                           output int starts, output bit addr_var, output bit timeout);
        logic [63:0] a0;
        bit          seen;
        int          c;
        a0 = bus.mm_addr; seen = 1'b0; c = 0;
        starts = 0; addr_var = 1'b0; dual = 1'b0; got = '0;
        while (!seen && c < 100) begin
            @(posedge clk); #1; c++;
            if (bus.mm_start === 1'b1) starts++;
            if (bus.mm_addr !== a0) addr_var = 1'b1;
            if (bus.if_ack === 1'b1 || bus.ls_ack === 1'b1) begin
                seen     = 1'b1;
                dual     = bus.if_ack & bus.ls_ack;
                got.is_ls = bus.ls_ack;
                got.data  = bus.ls_ack ? bus.ls_rdata : {32'h0, bus.if_data};
            end
        end
        timeout = !seen;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else                  want = {1'bx, 64'hx};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if ({bus.if_ack, bus.ls_ack} !== 2'b00)
            $display("FAIL reset_acks: got %b expected 00", {bus.if_ack, bus.ls_ack});
        else passed++;
        total++;
        if ({bus.if_data, bus.ls_rdata} !== '0)
            $display("FAIL reset_data: got if=%h ls=%h expected 0", bus.if_data, bus.ls_rdata);
        else passed++;
        total++;
        if ({bus.mm_start, bus.mm_op, bus.mm_size, bus.mm_addr, bus.mm_wdata} !== '0)
            $display("FAIL reset_mm: got start=%b op=%b size=%b addr=%h wdata=%h expected 0",
                     bus.mm_start, bus.mm_op, bus.mm_size, bus.mm_addr, bus.mm_wdata);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        exp_t want, got; logic dual; int starts; bit av, to; int lat; bit hit;
        exp_q.push_back({1'b0, 64'h0000_0000_0010_0513});
        drive_fetch(64'h100);
        lat = 0; hit = 1'b0;
        while (!hit && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (bus.mm_start === 1'b1) hit = 1'b1;
        end
        total++;
        if (!hit || lat != 1) $display("FAIL fetch_start_latency: got %0d cycles expected 1", lat);
        else passed++;
        total++;
        if ({bus.mm_op, bus.mm_size, bus.mm_addr} !== {1'b0, 2'b10, 64'h100})
            $display("FAIL fetch_issue_fields: got op=%b size=%b addr=%h expected op=0 size=10 addr=100",
                     bus.mm_op, bus.mm_size, bus.mm_addr);
        else passed++;
        collect(want, got, dual, starts, av, to);
        bus.if_req = 1'b0;
        total++;
        if (to || got !== want)
            $display("FAIL fetch_result: got ls=%0b data=%h expected ls=%0b data=%h",
                     got.is_ls, got.data, want.is_ls, want.data);
        else passed++;
        total++;
        if (dual !== 1'b0 || starts != 0 || av)
            $display("FAIL fetch_single_start: got dual=%b extra_starts=%0d addr_moved=%0b expected 0/0/0",
                     dual, starts, av);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.if_ack, bus.ls_ack} !== 2'b00)
            $display("FAIL fetch_ack_pulse: got %b one cycle after ack, expected 00", {bus.if_ack, bus.ls_ack});
        else passed++;
    endtask

    task automatic test_store_load();
        exp_t want, got; logic dual; int starts; bit av, to;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                exp_q.push_back({1'b1, 64'h0});
                drive_ls(1'b1, 2'b11, 1'b0, 64'h40, 64'h8877_6655_4433_2211);
            end else begin
                exp_q.push_back({1'b1, 64'h8877_6655_4433_2211});
                drive_ls(1'b0, 2'b11, 1'b0, 64'h40, 64'h0);
            end
            collect(want, got, dual, starts, av, to);
            bus.ls_req = 1'b0;
            total++;
            if (to || dual || got !== want)
                $display("FAIL store_load_%0d: got ls=%0b data=%h expected ls=%0b data=%h",
                         k, got.is_ls, got.data, want.is_ls, want.data);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_extension();
        exp_t want, got; logic dual; int starts; bit av, to;
        logic        t_we  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  t_sz  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        logic        t_uns [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] t_adr [7] = '{64'h48, 64'h48, 64'h50, 64'h50, 64'h60, 64'h60, 64'h60};
        logic [63:0] t_wd  [7] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0001, 64'h0, 64'h0};
        logic [63:0] t_exp [7] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0,
                                   64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                                   64'h0,
                                   64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001};
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back({1'b1, t_exp[k]});
            drive_ls(t_we[k], t_sz[k], t_uns[k], t_adr[k], t_wd[k]);
            collect(want, got, dual, starts, av, to);
            bus.ls_req = 1'b0;
            total++;
            if (to || dual || got !== want)
                $display("FAIL extension_%0d: got ls=%0b data=%h expected ls=%0b data=%h",
                         k, got.is_ls, got.data, want.is_ls, want.data);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_field_latch();
        exp_t want, got; logic dual; int starts; bit av, to; int c; bit hit;
        exp_q.push_back({1'b1, 64'h8877_6655_4433_2211});
        drive_ls(1'b0, 2'b11, 1'b0, 64'h40, 64'h0);
        c = 0; hit = 1'b0;
        while (!hit && c < 20) begin
            @(posedge clk); #1; c++;
            if (bus.mm_start === 1'b1) hit = 1'b1;
        end
        @(posedge clk); #1;
        bus.ls_addr  = 64'h80;
        bus.ls_wdata = 64'h1234_5678_9ABC_DEF0;
        bus.ls_req   = 1'b0;
        collect(want, got, dual, starts, av, to);
        total++;
        if (!hit || to || dual || got !== want)
            $display("FAIL latch_result: got ls=%0b data=%h expected ls=%0b data=%h",
                     got.is_ls, got.data, want.is_ls, want.data);
        else passed++;
        total++;
        if (av || bus.mm_addr !== 64'h40)
            $display("FAIL latch_mm_addr: got addr=%h moved=%0b expected addr=40 moved=0", bus.mm_addr, av);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        exp_t want, got; logic dual; int starts; bit av, to; bit extra;
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back({1'b1, 64'h8877_6655_4433_2211});
            else            exp_q.push_back({1'b0, 64'h0000_0000_0010_0513});
        end
        drive_fetch(64'h100);
        drive_ls(1'b0, 2'b11, 1'b0, 64'h40, 64'h0);
        for (int k = 0; k < 4; k++) begin
            collect(want, got, dual, starts, av, to);
            if (k == 3) begin bus.if_req = 1'b0; bus.ls_req = 1'b0; end
            total++;
            if (to || got !== want)
                $display("FAIL contention_order_%0d: got ls=%0b data=%h expected ls=%0b data=%h",
                         k, got.is_ls, got.data, want.is_ls, want.data);
            else passed++;
            total++;
            if (dual !== 1'b0 || starts != 1)
                $display("FAIL contention_starts_%0d: got starts=%0d dual=%b expected 1/0", k, starts, dual);
            else passed++;
            if (k == 1) begin
                total++;
                if (bus.ls_rdata !== 64'h8877_6655_4433_2211)
                    $display("FAIL ls_rdata_hold: got %h expected 8877665544332211", bus.ls_rdata);
                else passed++;
            end
        end
        extra = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.mm_start !== 1'b0 || bus.if_ack !== 1'b0 || bus.ls_ack !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra) $display("FAIL contention_idle: got activity after requests dropped, expected none");
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        exp_t want, got; logic dual; int starts; bit av, to; int c; bit hit; bit acked;
        drive_ls(1'b0, 2'b11, 1'b0, 64'h40, 64'h0);
        c = 0; hit = 1'b0;
        while (!hit && c < 20) begin
            @(posedge clk); #1; c++;
            if (bus.mm_start === 1'b1) hit = 1'b1;
        end
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        bus.ls_req = 1'b0;
        total++;
        if (!hit || {bus.if_ack, bus.ls_ack, bus.if_data, bus.ls_rdata, bus.mm_start,
                     bus.mm_op, bus.mm_size, bus.mm_addr, bus.mm_wdata} !== '0)
            $display("FAIL reset_wait_outputs: got ls_rdata=%h mm_addr=%h mm_size=%b started=%0b expected all 0",
                     bus.ls_rdata, bus.mm_addr, bus.mm_size, hit);
        else passed++;
        acked = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.if_ack !== 1'b0 || bus.ls_ack !== 1'b0) acked = 1'b1;
        end
        total++;
        if (acked) $display("FAIL reset_wait_no_ack: got an ack during reset, expected none");
        else passed++;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 64'h0000_0000_0010_0513});
        drive_fetch(64'h100);
        collect(want, got, dual, starts, av, to);
        bus.if_req = 1'b0;
        total++;
        if (to || dual || got !== want)
            $display("FAIL reset_wait_fetch: got ls=%0b data=%h expected ls=%0b data=%h",
                     got.is_ls, got.data, want.is_ls, want.data);
        else passed++;
        total++;
        if (bus.ls_rdata !== 64'h0)
            $display("FAIL reset_wait_ls_rdata: got %h expected 0", bus.ls_rdata);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.if_req      = 1'b0;
        bus.if_addr     = '0;
        bus.ls_req      = 1'b0;
        bus.ls_we       = 1'b0;
        bus.ls_size     = 2'b00;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr     = '0;
        bus.ls_wdata    = '0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_extension();
        test_field_latch();
        test_contention();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-serial memory_management engine between the instruction-fetch requester (IF) and the load/store requester (LS).
- Arbitrates between them, registers the winning request, and drives the engine's start/operation/size/address/data inputs stable for the whole transaction.
- Waits for the engine's done pulse, then returns fetch words or sign/zero-extended load data to the granted requester.

Parameters:
- XLEN, 64, address and data width of LS and engine ports.
- FETCH_SIZE, 2'b10, engine size code used for every fetch (2'b10 = 4 bytes).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request, level, held until if_ack.
- if_addr  input  XLEN  fetch byte address.
- if_ack  output  1  one-cycle completion pulse.
- if_data  output  32  fetched instruction, valid while if_ack=1.
- ls_req  input  1  load/store request, level, held until ls_ack.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  00=1B, 01=2B, 10=4B, 11=8B.
- ls_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- ls_addr  input  XLEN  byte address.
- ls_wdata  input  XLEN  store data, little-endian, low bytes used.
- ls_ack  output  1  one-cycle completion pulse.
- ls_rdata  output  XLEN  extended load data, valid while ls_ack=1; 0 for stores.
- mm_start  output  1  engine start pulse.
- mm_op  output  1  engine operation select, 1 = store.
- mm_size  output  2  engine size code.
- mm_addr  output  XLEN  engine address.
- mm_wdata  output  XLEN  engine store data.
- mm_done  input  1  engine completion pulse.
- mm_rdata  input  XLEN  engine load result, bytes assembled little-endian.

Behaviour:
- Reset (async, rst_n=0): state IDLE, last_grant=IF. All outputs 0: if_ack, ls_ack, if_data, ls_rdata, mm_start, mm_op, mm_size, mm_addr, mm_wdata. Latched request fields are cleared.
- Reset mid-transaction: arbiter returns to IDLE immediately and no ack is issued. The engine has no reset, so rst_n must be held low at least 20 clk cycles so an in-flight engine transaction drains.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither req set: stay in IDLE.
  - One req set: grant it.
  - Both set: grant the one that is not last_grant, so the first tie after reset goes to LS and alternation under contention is strict.
  - On grant, latch owner, op, size, address, wdata and unsigned flag into registers. IF grants use op=0 and size=FETCH_SIZE. Update last_grant. Next state ISSUE.
- ISSUE: mm_start=1 for exactly this cycle. mm_op, mm_size, mm_addr and mm_wdata come from the latches and stay constant from ISSUE through RESP. Next state WAIT.
- WAIT: mm_start=0. Stay until mm_done=1 is sampled. On that edge capture the result and go to RESP.
  - Fetch result: if_data = mm_rdata[31:0].
  - Load result, ls_unsigned=0: sign-extend from bit 7, 15, 31 or none for sizes 00, 01, 10, 11.
  - Load result, ls_unsigned=1: zero-extend for the same sizes.
  - Store result: ls_rdata = 0.
- RESP: the owner's ack=1 for one cycle. The other requester's ack stays 0. Next state IDLE.
- Data outputs if_data/ls_rdata hold their value until the next capture.
- Minimum turnaround: a request sampled in IDLE at edge N gives mm_start at N+1. Ack follows one cycle after mm_done. The next grant is considered on the edge after RESP, which is the cycle the engine re-enters its idle state.
- Requester rule: drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Request fields are latched at grant. Changing addr/data after grant does not affect the transaction.
- Deasserting req after grant does not abort the transaction; the ack still pulses.
- mm_done outside WAIT is ignored.
- A req rising while the other requester is in service waits in IDLE arbitration; there is no preemption.
- Address arithmetic: addresses pass through unmodified, with no alignment check; the engine increments bytes.

Test Plan:
- Single fetch: if_addr=0x100, memory bytes 0x13,0x05,0x10,0x00 -> mm_start 1 cycle, mm_size=10, mm_op=0; if_ack one pulse with if_data=0x00100513; ls_ack stays 0.
- Store then load: ls_we=1, size=11, addr=0x40, wdata=0x8877665544332211, then load 8B at 0x40 -> ls_rdata=0x8877665544332211.
- Sign/zero extension: byte 0xF0 at 0x48; load size=00 with ls_unsigned=0 -> 0xFFFFFFFFFFFFFFF0; with ls_unsigned=1 -> 0x00000000000000F0. Same for halfword 0x8001 -> 0xFFFFFFFFFFFF8001.
- Contention: if_req and ls_req rise in the same cycle after reset -> LS served first, IF second. Hold both high for 4 transactions -> grant order LS, IF, LS, IF.
- Field latching: change ls_addr from 0x40 to 0x80 one cycle after mm_start -> access still hits 0x40; mm_addr constant until ack.
- Async reset in WAIT: pull rst_n low mid-load for 20 cycles -> all outputs 0 immediately, no ack. After release, a new fetch completes correctly.
